// File: rtl/dma_engine_mc.sv
// dma_engine_mc: NUM_CH-channel MMIO-programmed word-copy DMA sharing one memory master.
// Channels are served round-robin one word (read beat + write beat) at a time.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMA_BASE_ADDR
`define DMA_BASE_ADDR 32'h0001_0000
`endif

module dma_engine_mc #(
    parameter int NUM_CH = 2,
    parameter logic [`ADDR_W-1:0] BASE_ADDR = `DMA_BASE_ADDR,
    parameter int CH_STRIDE = 32,
    parameter int LEN_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mmio_req,
    input  logic                mmio_we,
    input  logic [`ADDR_W-1:0]  mmio_addr,
    input  logic [`XLEN-1:0]    mmio_wdata,
    output logic [`XLEN-1:0]    mmio_rdata,
    output logic                mmio_ready,
    output logic                dma_mem_req,
    output logic                dma_mem_we,
    output logic [`ADDR_W-1:0]  dma_mem_addr,
    output logic [`XLEN-1:0]    dma_mem_wdata,
    input  logic [`XLEN-1:0]    dma_mem_rdata,
    input  logic                dma_mem_ready,
    output logic                dma_irq
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int AW = `ADDR_W;
    localparam int XW = `XLEN;

    typedef enum logic [1:0] {IDLE, ARB, RD, WR} state_t;
    state_t state, state_nx;

    logic [AW-1:0]     src [NUM_CH];
    logic [AW-1:0]     dst [NUM_CH];
    logic [XW-1:0]     len [NUM_CH];
    logic [LEN_W-1:0]  rem [NUM_CH];
    logic [NUM_CH-1:0] busy, done, err, irq_en, src_fix, dst_fix;
    logic [NUM_CH-1:0] ch_hit, start, abort_hit, is_sel, fin, cand, bad;
    logic [CW-1:0]     sel, rr_ptr, pick;
    logic [XW-1:0]     buf_q;
    logic              abort_pend, abort_sel, stop, last, beat, act;
    logic [AW-1:0]     off, roff, cidx;
    logic              in_ch, wr, r_src, r_dst, r_len, r_ctl, r_stat, r_clr;

    assign off    = mmio_addr - BASE_ADDR;
    assign in_ch  = off < AW'(NUM_CH * CH_STRIDE);
    assign cidx   = off / AW'(CH_STRIDE);
    assign roff   = off % AW'(CH_STRIDE);
    assign wr     = mmio_req && mmio_we && in_ch;
    assign r_src  = roff == AW'('h00);
    assign r_dst  = roff == AW'('h04);
    assign r_len  = roff == AW'('h08);
    assign r_ctl  = roff == AW'('h0C);
    assign r_stat = roff == AW'('h10);
    assign r_clr  = roff == AW'('h14);
    assign mmio_ready = mmio_req;

    assign act       = state == RD || state == WR;
    assign beat      = state == WR && dma_mem_ready;
    assign abort_sel = |(abort_hit & is_sel);
    assign stop      = abort_pend || abort_sel;
    assign last      = rem[sel] == LEN_W'(1) || stop;
    assign cand      = busy & ~abort_hit;

    always_comb begin
        ch_hit = '0;
        start = '0;
        abort_hit = '0;
        is_sel = '0;
        fin = '0;
        bad = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_hit[c]    = in_ch && cidx == AW'(c);
            start[c]     = wr && ch_hit[c] && r_ctl && mmio_wdata[0] && !busy[c];
            abort_hit[c] = wr && ch_hit[c] && r_ctl && mmio_wdata[4] && busy[c];
            is_sel[c]    = act && sel == CW'(c);
            fin[c]       = beat && is_sel[c] && last;
            bad[c]       = len[c][1:0] != 2'b0 || src[c][1:0] != 2'b0 || dst[c][1:0] != 2'b0 ||
                           (len[c] >> (LEN_W + 2)) != '0;
        end
    end

    // first candidate at or after rr_ptr: scan downwards so the nearest one wins
    always_comb begin
        pick = rr_ptr;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (cand[(int'(rr_ptr) + k) % NUM_CH]) pick = CW'((int'(rr_ptr) + k) % NUM_CH);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = |busy ? ARB : IDLE;
            ARB:  state_nx = |cand ? RD : IDLE;
            RD:   state_nx = dma_mem_ready ? WR : RD;
            WR:   state_nx = !dma_mem_ready ? WR : |(busy & ~fin) ? ARB : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign dma_mem_req   = act;
    assign dma_mem_we    = state == WR;
    assign dma_mem_addr  = state == RD ? src[sel] : state == WR ? dst[sel] : '0;
    assign dma_mem_wdata = state == WR ? buf_q : '0;

    always_comb begin
        mmio_rdata = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (ch_hit[c])
                mmio_rdata = r_src  ? XW'(src[c]) :
                             r_dst  ? XW'(dst[c]) :
                             r_len  ? len[c] :
                             r_ctl  ? XW'({dst_fix[c], src_fix[c], irq_en[c], 1'b0}) :
                             r_stat ? XW'({err[c], done[c], busy[c]}) : '0;
        if (off == AW'('h100)) mmio_rdata = XW'(done) | (XW'(busy) << 16);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            rr_ptr     <= '0;
            buf_q      <= '0;
            abort_pend <= 1'b0;
            dma_irq    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ARB) sel <= pick;
            if (state == RD && dma_mem_ready) buf_q <= dma_mem_rdata;
            if (beat) rr_ptr <= sel == CW'(NUM_CH - 1) ? '0 : sel + CW'(1);
            abort_pend <= beat ? 1'b0 : abort_pend || abort_sel;
            dma_irq <= |((done | err) & irq_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                src[c] <= '0;
                dst[c] <= '0;
                len[c] <= '0;
                rem[c] <= '0;
            end
            busy    <= '0;
            done    <= '0;
            err     <= '0;
            irq_en  <= '0;
            src_fix <= '0;
            dst_fix <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr && ch_hit[c] && !busy[c]) begin
                    if (r_src) src[c] <= AW'(mmio_wdata);
                    if (r_dst) dst[c] <= AW'(mmio_wdata);
                    if (r_len) len[c] <= mmio_wdata;
                end
                if (wr && ch_hit[c] && r_ctl) begin
                    irq_en[c]  <= mmio_wdata[1];
                    src_fix[c] <= mmio_wdata[2];
                    dst_fix[c] <= mmio_wdata[3];
                end
                // clears come first so a same-cycle set overrides them
                if (wr && ch_hit[c] && r_clr) begin
                    if (mmio_wdata[0]) done[c] <= 1'b0;
                    if (mmio_wdata[1]) err[c] <= 1'b0;
                end
                if (start[c]) begin
                    if (len[c] == '0) done[c] <= 1'b1;
                    else if (bad[c]) {done[c], err[c]} <= 2'b11;
                    else begin
                        busy[c] <= 1'b1;
                        rem[c]  <= LEN_W'(len[c] >> 2);
                    end
                end
                if (abort_hit[c] && !is_sel[c]) {busy[c], done[c], err[c]} <= 3'b011;
                if (beat && is_sel[c]) begin
                    if (!src_fix[c]) src[c] <= src[c] + AW'(4);
                    if (!dst_fix[c]) dst[c] <= dst[c] + AW'(4);
                    rem[c] <= rem[c] - LEN_W'(1);
                    if (last) {busy[c], done[c]} <= 2'b01;
                    if (stop) err[c] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dma_engine_mc.sv
// tb_dma_engine_mc: directed bench with a word-level round-robin copy model and a memory responder.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMA_BASE_ADDR
`define DMA_BASE_ADDR 32'h0001_0000
`endif

module tb_dma_engine_mc;
    localparam int N = 2;
    localparam logic [31:0] BASE = `DMA_BASE_ADDR;
    localparam logic [31:0] GSTAT = BASE + 32'h100;

    logic clk = 1'b0, rst_n = 1'b0;
    logic mmio_req = 1'b0, mmio_we = 1'b0;
    logic [31:0] mmio_addr = '0, mmio_wdata = '0, mmio_rdata;
    logic mmio_ready, dma_mem_req, dma_mem_we, dma_irq;
    logic [31:0] dma_mem_addr, dma_mem_wdata, dma_mem_rdata;
    logic dma_mem_ready = 1'b1;

    dma_engine_mc #(.NUM_CH(N)) dut (
        .clk(clk), .rst_n(rst_n), .mmio_req(mmio_req), .mmio_we(mmio_we),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
        .mmio_ready(mmio_ready), .dma_mem_req(dma_mem_req), .dma_mem_we(dma_mem_we),
        .dma_mem_addr(dma_mem_addr), .dma_mem_wdata(dma_mem_wdata),
        .dma_mem_rdata(dma_mem_rdata), .dma_mem_ready(dma_mem_ready), .dma_irq(dma_irq)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign dma_mem_rdata = mem[dma_mem_addr[11:2]];

    int pass_n = 0, total_n = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // word-level model: which channel owns the next pair, and where it must read/write
    bit          m_busy [N];
    bit          m_sfix [N];
    bit          m_dfix [N];
    bit          m_abort [N];
    logic [31:0] m_src [N];
    logic [31:0] m_dst [N];
    logic [31:0] m_len [N];
    int          m_rem [N];
    int          m_rr = 0, m_phase = 0, m_cur = 0, beats = 0;
    logic [31:0] m_buf;
    int          rmode = 0;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_busy[c] = 0; m_abort[c] = 0; m_sfix[c] = 0; m_dfix[c] = 0;
            m_src[c] = 0; m_dst[c] = 0; m_len[c] = 0; m_rem[c] = 0;
        end
        m_rr = 0; m_phase = 0; m_cur = 0;
    endtask

    task automatic model_step();
        bit found;
        int idx;
        if (!dma_mem_we) begin
            if (m_phase == 2) check("rd_phase", 32'(m_phase), 1);
            if (m_phase == 0) begin
                found = 0;
                for (int k = N - 1; k >= 0; k--) begin
                    idx = (m_rr + k) % N;
                    if (m_busy[idx]) begin m_cur = idx; found = 1; end
                end
                check("rd_has_channel", 32'(found), 1);
                if (found) m_phase = 1;
            end
            if (m_phase == 1) begin
                check("rd_addr", dma_mem_addr, m_src[m_cur]);
                if (dma_mem_ready) begin
                    m_buf = mem[m_src[m_cur][11:2]];
                    m_phase = 2;
                end
            end
        end else begin
            check("wr_phase", 32'(m_phase), 2);
            if (m_phase == 2) begin
                check("wr_addr", dma_mem_addr, m_dst[m_cur]);
                check("wr_data", dma_mem_wdata, m_buf);
                if (dma_mem_ready) begin
                    mem[dma_mem_addr[11:2]] = dma_mem_wdata;
                    beats++;
                    if (!m_sfix[m_cur]) m_src[m_cur] += 4;
                    if (!m_dfix[m_cur]) m_dst[m_cur] += 4;
                    m_rem[m_cur]--;
                    m_rr = (m_cur + 1) % N;
                    if (m_rem[m_cur] == 0 || m_abort[m_cur]) begin
                        m_busy[m_cur] = 0; m_abort[m_cur] = 0;
                    end
                    m_phase = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && dma_mem_req) model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        dma_mem_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : !dma_mem_we;
    end

    function automatic logic [31:0] ra(input int c, input logic [31:0] o);
        return BASE + 32'(c * 32) + o;
    endfunction

    task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        mmio_req = 1; mmio_we = 1; mmio_addr = a; mmio_wdata = d;
        @(posedge clk); #1;
        mmio_req = 0; mmio_we = 0;
    endtask

    task automatic mmio_rd(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #2;
        mmio_req = 1; mmio_we = 0; mmio_addr = a;
        #1 d = mmio_rdata;
        mmio_req = 0;
    endtask

    task automatic setup(input int c, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        mmio_wr(ra(c, 'h0), s);
        mmio_wr(ra(c, 'h4), d);
        mmio_wr(ra(c, 'h8), l);
        if (!m_busy[c]) begin m_src[c] = s; m_dst[c] = d; m_len[c] = l; end
    endtask

    task automatic go(input int c, input logic [31:0] ctl);
        mmio_wr(ra(c, 'hC), ctl);
        m_sfix[c] = ctl[2]; m_dfix[c] = ctl[3];
        if (ctl[4] && m_busy[c]) begin
            if (m_phase != 0 && m_cur == c) m_abort[c] = 1;
            else m_busy[c] = 0;
        end else if (ctl[0] && !m_busy[c] && m_len[c] != 0 && m_len[c][1:0] == 0 &&
                     m_src[c][1:0] == 0 && m_dst[c][1:0] == 0) begin
            m_busy[c] = 1; m_rem[c] = int'(m_len[c] >> 2);
        end
    endtask

    task automatic wait_idle();
        logic [31:0] g;
        int n = 0;
        do begin mmio_rd(GSTAT, g); n++; end while (g[17:16] != 0 && n < 2000);
        check("idle_reached", {30'b0, g[17:16]}, 0);
    endtask

    logic [31:0] rd;
    int b0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem[('h100 >> 2) + i] = 32'hA5A5_0000 + 32'(i);
        for (int i = 0; i < 16; i++) mem[('h400 >> 2) + i] = 32'h1000 + 32'(i);
        mem['h300 >> 2] = 32'hCAFE_0001;
        for (int i = 1; i < 4; i++) mem[('h300 >> 2) + i] = 32'h1111_1111;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {31'b0, dma_mem_req}, 0);
        check("rst_we", {31'b0, dma_mem_we}, 0);
        check("rst_addr", dma_mem_addr, 0);
        check("rst_wdata", dma_mem_wdata, 0);
        check("rst_irq", {31'b0, dma_irq}, 0);
        rst_n = 1;
        mmio_rd(GSTAT, rd); check("rst_gstat", rd, 0);
        mmio_rd(ra(0, 'h10), rd); check("rst_stat0", rd, 0);

        // single-channel copy with interrupt
        setup(0, 'h100, 'h200, 16);
        go(0, 32'h3);
        wait_idle();
        for (int i = 0; i < 4; i++) check("t1_dst", mem[('h200 >> 2) + i], 32'hA5A5_0000 + 32'(i));
        mmio_rd(ra(0, 'h10), rd); check("t1_stat", rd, 2);
        mmio_rd(ra(0, 'hC), rd); check("t1_ctrl", rd, 2);
        repeat (8) begin @(posedge clk); #3; check("t1_irq_held", {31'b0, dma_irq}, 1); end
        mmio_wr(ra(0, 'h14), 3);
        @(posedge clk); #3;
        check("t1_irq_clr", {31'b0, dma_irq}, 0);
        mmio_rd(ra(0, 'h10), rd); check("t1_stat_clr", rd, 0);

        // two channels interleaved word by word
        setup(0, 'h400, 'h500, 32);
        setup(1, 'h420, 'h540, 32);
        go(1, 32'h1);
        go(0, 32'h1);
        wait_idle();
        for (int i = 0; i < 8; i++) check("t2_dst0", mem[('h500 >> 2) + i], 32'h1000 + 32'(i));
        for (int i = 0; i < 8; i++) check("t2_dst1", mem[('h540 >> 2) + i], 32'h1008 + 32'(i));
        mmio_rd(GSTAT, rd); check("t2_gstat", rd, 32'h3);
        mmio_wr(ra(0, 'h14), 3);
        mmio_wr(ra(1, 'h14), 3);

        // fixed source address
        setup(1, 'h300, 'h600, 16);
        go(1, 32'h5);
        wait_idle();
        for (int i = 0; i < 4; i++) check("t3_dst", mem[('h600 >> 2) + i], 32'hCAFE_0001);
        mmio_rd(ra(1, 'h0), rd); check("t3_src_fixed", rd, 'h300);
        mmio_rd(ra(1, 'h4), rd); check("t3_dst_moved", rd, 'h610);
        mmio_wr(ra(1, 'h14), 3);

        // zero length and malformed jobs
        b0 = beats;
        setup(0, 'h100, 'h200, 0);
        go(0, 32'h1);
        repeat (4) @(posedge clk);
        mmio_rd(ra(0, 'h10), rd); check("t4_len0_stat", rd, 2);
        check("t4_len0_beats", 32'(beats - b0), 0);
        mmio_wr(ra(0, 'h14), 3);
        setup(0, 'h100, 'h200, 6);
        go(0, 32'h1);
        mmio_rd(ra(0, 'h10), rd); check("t4_len6_stat", rd, 6);
        mmio_wr(ra(0, 'h14), 3);
        setup(0, 'h102, 'h200, 16);
        go(0, 32'h1);
        mmio_rd(ra(0, 'h10), rd); check("t4_src_unaligned", rd, 6);
        check("t4_bad_beats", 32'(beats - b0), 0);
        mmio_wr(ra(0, 'h14), 3);

        // restart and reprogram attempts while busy
        setup(0, 'h100, 'h700, 16);
        go(0, 32'h1);
        setup(0, 'h104, 'h900, 4);
        go(0, 32'h3);
        wait_idle();
        check("t4_busy_w0", mem['h700 >> 2], 32'hA5A5_0000);
        check("t4_busy_w3", mem[('h700 >> 2) + 3], 32'hA5A5_0003);
        mmio_rd(ra(0, 'h4), rd); check("t4_busy_dst", rd, 'h710);
        mmio_rd(ra(0, 'h10), rd); check("t4_busy_stat", rd, 2);
        mmio_wr(ra(0, 'h14), 3);
        mmio_wr(ra(0, 'hC), 0);

        // abort mid-transfer with random stalls
        rmode = 1;
        b0 = beats;
        setup(0, 'h100, 'h800, 64);
        go(0, 32'h1);
        repeat (20) @(posedge clk);
        go(0, 32'h10);
        repeat (60) @(posedge clk);
        rmode = 0;
        mmio_rd(ra(0, 'h10), rd); check("t5_abort_stat", rd, 6);
        mmio_rd(GSTAT, rd); check("t5_abort_busy", {15'b0, rd[16:0]}, 1);
        check("t5_first_word", mem['h800 >> 2], 32'hA5A5_0000);
        check("t5_short", 32'(beats - b0 < 16), 1);
        check("t5_model_idle", 32'(m_busy[0]), 0);
        mmio_wr(ra(0, 'h14), 3);

        // asynchronous reset while a write beat is stalled
        rmode = 2;
        setup(0, 'h100, 'hA00, 16);
        go(0, 32'h1);
        b0 = 0;
        while (!(dma_mem_req && dma_mem_we) && b0 < 100) begin @(negedge clk); b0++; end
        check("t6_wr_seen", {31'b0, dma_mem_we}, 1);
        #2 rst_n = 0;
        #1 check("t6_req_drop", {31'b0, dma_mem_req}, 0);
        model_reset();
        rmode = 0;
        @(posedge clk); #1 rst_n = 1;
        mmio_rd(ra(0, 'h10), rd); check("t6_stat0", rd, 0);
        mmio_rd(ra(1, 'h10), rd); check("t6_stat1", rd, 0);
        mmio_rd(GSTAT, rd); check("t6_gstat", rd, 0);
        repeat (5) @(posedge clk);
        #1 check("t6_no_req", {31'b0, dma_mem_req}, 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
